// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: loads an R x N_OUT golden table, then drives every input row to an external DUT and tallies mismatches.
// Lookup latency 1 cycle; sweep takes R cycles; cfg_ready is the only backpressure and is high for the whole LOAD state.
module tt_sweep_checker #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [N_OUT-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             tbl_ok,
  input  logic             lk_valid,
  input  logic [N_IN-1:0]  lk_in,
  output logic             lk_out_valid,
  output logic [N_OUT-1:0] lk_out,
  input  logic             sw_start,
  input  logic             sw_abort,
  output logic [N_IN-1:0]  dut_in,
  output logic             dut_in_valid,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             first_fail_valid
);

  localparam int R = 1 << N_IN;
  localparam logic [N_IN-1:0] ROW_MAX = '1;
  localparam logic [N_IN-1:0] ROW_ONE = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic [N_OUT-1:0]  tbl_q [R];
  logic [N_IN-1:0]   wr_ptr_q;
  logic [N_IN-1:0]   row_q;

  logic              idle_like;
  logic              start_load;
  logic              start_sweep;
  logic              load_wr;
  logic              load_last;
  logic              sweep_abort;
  logic              sweep_cmp;
  logic              sweep_last;
  logic              mismatch;
  logic              lk_take;
  logic [N_IN:0]     err_nxt;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    idle_like   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    start_load  = idle_like && cfg_start;
    start_sweep = idle_like && sw_start && tbl_ok && !cfg_start;
    load_wr     = (state_q == ST_LOAD) && cfg_valid;
    load_last   = load_wr && (wr_ptr_q == ROW_MAX);
    sweep_abort = (state_q == ST_SWEEP) && sw_abort;
    sweep_cmp   = (state_q == ST_SWEEP) && !sw_abort;
    sweep_last  = sweep_cmp && (row_q == ROW_MAX);
    mismatch    = (dut_out != tbl_q[row_q]);
    err_nxt     = err_cnt + (N_IN+1)'(mismatch);
    lk_take     = lk_valid && idle_like && tbl_ok;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_load) begin
          state_d = ST_LOAD;
        end else if (start_sweep) begin
          state_d = ST_SWEEP;
        end
      end
      ST_LOAD: begin
        if (load_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (sweep_abort) begin
          state_d = ST_IDLE;
        end else if (sweep_last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < R; i++) begin
        tbl_q[i] <= '0;
      end
      wr_ptr_q         <= '0;
      row_q            <= '0;
      tbl_ok           <= 1'b0;
      lk_out_valid     <= 1'b0;
      lk_out           <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      lk_out_valid <= 1'b0;
      if (lk_take) begin
        lk_out_valid <= 1'b1;
        lk_out       <= tbl_q[lk_in];
      end

      if (start_load) begin
        wr_ptr_q <= '0;
        tbl_ok   <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else if (start_sweep) begin
        row_q            <= '0;
        err_cnt          <= '0;
        first_fail       <= '0;
        first_fail_valid <= 1'b0;
        done             <= 1'b0;
        pass             <= 1'b0;
      end

      if (load_wr) begin
        tbl_q[wr_ptr_q] <= cfg_data;
        wr_ptr_q        <= wr_ptr_q + ROW_ONE;
        if (load_last) begin
          tbl_ok <= 1'b1;
        end
      end

      if (sweep_abort) begin
        row_q            <= '0;
        err_cnt          <= '0;
        first_fail       <= '0;
        first_fail_valid <= 1'b0;
        done             <= 1'b0;
        pass             <= 1'b0;
      end else if (sweep_cmp) begin
        // row_q wraps back to 0 after the last row, ready for the next sweep.
        err_cnt <= err_nxt;
        row_q   <= row_q + ROW_ONE;
        if (mismatch && !first_fail_valid) begin
          first_fail       <= row_q;
          first_fail_valid <= 1'b1;
        end
        if (sweep_last) begin
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end
      end
    end
  end

  always_comb begin
    cfg_ready    = (state_q == ST_LOAD);
    busy         = (state_q == ST_LOAD) || (state_q == ST_SWEEP);
    dut_in_valid = (state_q == ST_SWEEP);
    dut_in       = (state_q == ST_SWEEP) ? row_q : '0;
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker (N_IN=4, N_OUT=1) with a table-driven behavioural DUT.
module tb_tt_sweep_checker;

  localparam int N_IN  = 4;
  localparam int N_OUT = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_start, cfg_valid;
  logic [N_OUT-1:0] cfg_data;
  logic             cfg_ready, tbl_ok;
  logic             lk_valid;
  logic [N_IN-1:0]  lk_in;
  logic             lk_out_valid;
  logic [N_OUT-1:0] lk_out;
  logic             sw_start, sw_abort;
  logic [N_IN-1:0]  dut_in;
  logic             dut_in_valid;
  logic [N_OUT-1:0] dut_out;
  logic             busy, done, pass;
  logic [N_IN:0]    err_cnt;
  logic [N_IN-1:0]  first_fail;
  logic             first_fail_valid;

  logic [15:0]      dut_model;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] idx;
    logic       exp;
  } lk_vec_t;

  typedef struct {
    logic [15:0] model;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        ffv;
    logic        pass;
  } sw_vec_t;

  lk_vec_t lk_tab [4];
  sw_vec_t sw_tab [4];

  always #5 clk = ~clk;

  assign dut_out = dut_model[dut_in];

  tt_sweep_checker #(.N_IN(N_IN), .N_OUT(N_OUT)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_ready        (cfg_ready),
    .tbl_ok           (tbl_ok),
    .lk_valid         (lk_valid),
    .lk_in            (lk_in),
    .lk_out_valid     (lk_out_valid),
    .lk_out           (lk_out),
    .sw_start         (sw_start),
    .sw_abort         (sw_abort),
    .dut_in           (dut_in),
    .dut_in_valid     (dut_in_valid),
    .dut_out          (dut_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .first_fail       (first_fail),
    .first_fail_valid (first_fail_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({cfg_ready, tbl_ok, lk_out_valid, lk_out, dut_in, dut_in_valid,
                busy, done, pass, err_cnt, first_fail, first_fail_valid});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic [15:0] bits, input bit gaps, input bit with_sw);
    cfg_start = 1'b1;
    sw_start  = with_sw;
    tick();
    cfg_start = 1'b0;
    sw_start  = 1'b0;
    chk("load_entered", 32'(cfg_ready), 32'd1);
    chk("load_tbl_ok_clr", 32'(tbl_ok), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 2 == 1)) begin
        cfg_valid = 1'b0;
        cfg_start = (i == 9);
        sw_start  = (i == 9);
        tick();
        cfg_start = 1'b0;
        sw_start  = 1'b0;
        if (i == 9) chk("start_in_load_ignored", 32'({cfg_ready, busy, dut_in_valid}), 32'b110);
      end
      cfg_valid = 1'b1;
      cfg_data  = bits[i];
      if (i == 15) chk("tbl_ok_before_last", 32'(tbl_ok), 32'd0);
      tick();
    end
    cfg_valid = 1'b0;
    chk("tbl_ok_after_last", 32'({tbl_ok, cfg_ready, busy}), 32'b100);
  endtask

  task automatic run_sweep(input sw_vec_t v, input string name);
    bit steps_ok;
    dut_model = v.model;
    sw_start  = 1'b1;
    tick();
    sw_start = 1'b0;
    steps_ok = 1'b1;
    for (int r = 0; r < 16; r++) begin
      if (dut_in !== 4'(r) || dut_in_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) steps_ok = 1'b0;
      tick();
    end
    chk({name, "_steps"}, 32'(steps_ok), 32'd1);
    chk({name, "_done"}, 32'({done, busy, dut_in_valid}), 32'b100);
    chk({name, "_pass"}, 32'(pass), 32'(v.pass));
    chk({name, "_err_cnt"}, 32'(err_cnt), 32'(v.err));
    chk({name, "_first_fail"}, 32'({first_fail_valid, first_fail}), 32'({v.ffv, v.ff}));
  endtask

  task automatic abort_at(input int k);
    dut_model = 16'hEF69 ^ 16'h0010;
    sw_start  = 1'b1;
    tick();
    sw_start = 1'b0;
    repeat (k) tick();
    chk("abort_row", 32'(dut_in), 32'(k));
    chk("abort_err_before", 32'(err_cnt), (k > 4) ? 32'd1 : 32'd0);
    lk_valid = 1'b1;
    lk_in    = 4'd0;
    sw_abort = 1'b1;
    tick();
    lk_valid = 1'b0;
    sw_abort = 1'b0;
    chk("lookup_in_sweep_dropped", 32'(lk_out_valid), 32'd0);
    chk("abort_cleared", 32'({busy, done, pass, err_cnt, first_fail_valid, dut_in_valid, dut_in}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;

    lk_tab[0] = '{4'd0,  1'b1};
    lk_tab[1] = '{4'd1,  1'b0};
    lk_tab[2] = '{4'd3,  1'b1};
    lk_tab[3] = '{4'd12, 1'b0};

    sw_tab[0] = '{16'hEF69, 5'd0,  4'd0,  1'b0, 1'b1};
    sw_tab[1] = '{16'hED49, 5'd2,  4'd5,  1'b1, 1'b0};
    sw_tab[2] = '{16'h1096, 5'd16, 4'd0,  1'b1, 1'b0};
    sw_tab[3] = '{16'h6F69, 5'd1,  4'd15, 1'b1, 1'b0};

    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    lk_valid  = 1'b0; lk_in = '0;
    sw_start  = 1'b0; sw_abort = 1'b0;
    dut_model = 16'h0000;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1 chk("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", all_outs(), 32'd0);

    // Nothing loaded yet: lookups and sweeps are refused.
    lk_valid = 1'b1; lk_in = 4'd3; sw_start = 1'b1;
    tick();
    lk_valid = 1'b0; sw_start = 1'b0;
    chk("no_table_lookup_drop", 32'(lk_out_valid), 32'd0);
    chk("no_table_sweep_ignored", 32'({busy, dut_in_valid}), 32'd0);

    load_table(16'hEF69, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      lk_valid = 1'b1;
      lk_in    = lk_tab[i].idx;
      tick();
      chk($sformatf("lookup_row%0d", lk_tab[i].idx), 32'({lk_out_valid, lk_out}), 32'({1'b1, lk_tab[i].exp}));
    end
    lk_valid = 1'b0;
    tick();
    chk("lookup_idle_hold", 32'({lk_out_valid, lk_out}), 32'b00);

    for (int i = 0; i < 4; i++) begin
      run_sweep(sw_tab[i], $sformatf("sweep%0d", i));
    end

    // Results stay put in DONE; sw_abort outside SWEEP does nothing.
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    repeat (2) tick();
    chk("done_hold", 32'({done, pass, err_cnt, first_fail_valid, first_fail, busy}), 32'({1'b1, 1'b0, 5'd1, 1'b1, 4'd15, 1'b0}));
    lk_valid = 1'b1; lk_in = 4'd13;
    tick();
    lk_valid = 1'b0;
    chk("lookup_in_done", 32'({lk_out_valid, lk_out}), 32'b11);

    abort_at(7);
    run_sweep(sw_tab[0], "restart_after_abort");
    abort_at(0);

    // cfg_start and sw_start together in IDLE must choose LOAD.
    pat = 16'hA5C3;
    load_table(pat, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      lk_valid = 1'b1;
      lk_in    = 4'(i);
      tick();
      chk($sformatf("gapped_row%0d", i), 32'({lk_out_valid, lk_out}), 32'({1'b1, pat[i]}));
    end
    lk_valid = 1'b0;
    tick();
    chk("lookup_out_held", 32'({lk_out_valid, lk_out}), 32'b01);

    dut_model = pat ^ 16'h0004;
    sw_start  = 1'b1;
    tick();
    sw_start = 1'b0;
    repeat (5) tick();
    chk("mid_sweep_state", 32'({dut_in, err_cnt, busy}), 32'({4'd5, 5'd1, 1'b1}));
    #3 rst_n = 1'b0;
    #1 chk("reset_mid_sweep", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    sw_start = 1'b1; lk_valid = 1'b1; lk_in = 4'd0;
    tick();
    sw_start = 1'b0; lk_valid = 1'b0;
    chk("sweep_after_reset_ignored", 32'({busy, dut_in_valid, tbl_ok, done}), 32'd0);
    chk("lookup_after_reset_dropped", 32'(lk_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
